// File: rtl/mems_scan_sequencer.sv
// mems_scan_sequencer
// -------------------
// Purpose: sequences commands for a MEMS mirror scan. The block feeds the DAC
// SPI master a command-ROM address together with a one-cycle start pulse.
// It first replays the init command list at ROM 0..INIT_LEN-1. It then sweeps
// the scan region SCAN_BASE..SCAN_END, which is organised as points per line,
// lines per frame and frames per pass. Line and frame boundary flags go to the
// readout logic and clear on acknowledge.
//
// Ports:
//   clk_i, rst_i         clock; asynchronous active-high reset
//   start_i              begin the sequence (level-sampled in IDLE/DONE)
//   pause_i              hold scan issuing (ignored during init)
//   continuous_i         1: wrap forever, 0: stop after one pass
//   spi_busy_i           SPI master busy
//   line_ack_i           clears new_line_o
//   frame_ack_i          clears new_frame_o
//   spi_start_o          one-cycle command start pulse
//   addr_o               ROM address of the command being started
//   new_line_o           line-boundary flag
//   new_frame_o          frame-boundary flag
//   line_idx_o           line index of the point just issued
//   frame_idx_o          frame index of the point just issued
//   scan_active_o        high while in SCAN
//   overrun_o            sticky: a boundary flag was set while still pending
//   state_o              FSM state (IDLE=0, INIT=1, SCAN=2, DONE=3), for debug
//
// Handshake with the SPI master: a command is issued only when spi_busy_i is
// low and no pulse went out in the previous cycle. This guarantees at least
// one gap cycle between pulses, so the master has time to raise busy.
// addr_o changes in the pulse cycle and then holds until the next pulse.
module mems_scan_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int INIT_LEN  = 2,
  parameter int SCAN_BASE = 8,
  parameter int LINE_LEN  = 720,
  parameter int LINES     = 2,
  parameter int FRAMES    = 9,
  localparam int LW = (LINES  > 1) ? $clog2(LINES)  : 1,
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              pause_i,
  input  logic              continuous_i,
  input  logic              spi_busy_i,
  input  logic              line_ack_i,
  input  logic              frame_ack_i,
  output logic              spi_start_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              new_line_o,
  output logic              new_frame_o,
  output logic [LW-1:0]     line_idx_o,
  output logic [FW-1:0]     frame_idx_o,
  output logic              scan_active_o,
  output logic              overrun_o,
  output logic [1:0]        state_o
);

  localparam int CW = $clog2(LINE_LEN);

  localparam logic [ADDR_W-1:0] INIT_LAST   = ADDR_W'(INIT_LEN - 1);
  localparam logic [ADDR_W-1:0] SCAN_BASE_A = ADDR_W'(SCAN_BASE);
  localparam logic [ADDR_W-1:0] SCAN_END_A  =
    ADDR_W'(SCAN_BASE + LINE_LEN * LINES * FRAMES - 1);
  localparam logic [CW-1:0]     COL_LAST    = CW'(LINE_LEN - 1);
  localparam logic [LW-1:0]     LINE_LAST   = LW'(LINES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              spi_start_q, spi_start_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     col_q, col_d;      // point index within the line
  logic [LW-1:0]     line_q, line_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic              new_line_q, new_line_d;
  logic              new_frame_q, new_frame_d;
  logic              scan_active_q, scan_active_d;
  logic              overrun_q, overrun_d;

  logic go;
  logic point_issue;  // a scan point is issued in this cycle
  logic overrun_clr;
  logic end_of_line;
  logic set_line;
  logic set_frame;

  assign go = !spi_busy_i && !spi_start_q;

  // FSM next-state and issue logic.
  always_comb begin
    state_d     = state_q;
    spi_start_d = 1'b0;
    addr_d      = addr_q;
    col_d       = col_q;
    line_d      = line_q;
    frame_d     = frame_q;
    point_issue = 1'b0;
    overrun_clr = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          spi_start_d = 1'b1;
          addr_d      = '0;
          overrun_clr = 1'b1;
          state_d     = INIT;
        end
      end

      INIT: begin
        if (go) begin
          spi_start_d = 1'b1;
          if (addr_q == INIT_LAST) begin
            addr_d      = SCAN_BASE_A;
            col_d       = '0;
            line_d      = '0;
            frame_d     = '0;
            point_issue = 1'b1;
            state_d     = SCAN;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end

      SCAN: begin
        if (addr_q == SCAN_END_A && !continuous_i) begin
          // The single pass is complete. addr stays at SCAN_END.
          state_d = DONE;
        end else if (go && !pause_i) begin
          spi_start_d = 1'b1;
          point_issue = 1'b1;
          if (addr_q == SCAN_END_A) begin
            addr_d  = SCAN_BASE_A;
            col_d   = '0;
            line_d  = '0;
            frame_d = '0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (col_q == COL_LAST) begin
              col_d = '0;
              if (line_q == LINE_LAST) begin
                line_d  = '0;
                frame_d = frame_q + FW'(1);
              end else begin
                line_d = line_q + LW'(1);
              end
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
      end

      DONE: begin
        // Restart the scan without replaying init.
        if (start_i) begin
          spi_start_d = 1'b1;
          addr_d      = SCAN_BASE_A;
          col_d       = '0;
          line_d      = '0;
          frame_d     = '0;
          point_issue = 1'b1;
          state_d     = SCAN;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Boundary flags are raised together with the pulse of the last point of a
  // line. The last line of a frame raises only the frame flag.
  always_comb begin
    end_of_line = point_issue && (col_d == COL_LAST);
    set_frame   = end_of_line && (line_d == LINE_LAST);
    set_line    = end_of_line && (line_d != LINE_LAST);

    // If a set and an ack arrive in the same cycle, the set wins.
    new_line_d  = set_line  || (new_line_q  && !line_ack_i);
    new_frame_d = set_frame || (new_frame_q && !frame_ack_i);

    if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q
                || (set_line  && new_line_q  && !line_ack_i)
                || (set_frame && new_frame_q && !frame_ack_i);
    end

    scan_active_d = (state_d == SCAN);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      spi_start_q   <= 1'b0;
      addr_q        <= '0;
      col_q         <= '0;
      line_q        <= '0;
      frame_q       <= '0;
      new_line_q    <= 1'b0;
      new_frame_q   <= 1'b0;
      scan_active_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      spi_start_q   <= spi_start_d;
      addr_q        <= addr_d;
      col_q         <= col_d;
      line_q        <= line_d;
      frame_q       <= frame_d;
      new_line_q    <= new_line_d;
      new_frame_q   <= new_frame_d;
      scan_active_q <= scan_active_d;
      overrun_q     <= overrun_d;
    end
  end

  assign spi_start_o   = spi_start_q;
  assign addr_o        = addr_q;
  assign new_line_o    = new_line_q;
  assign new_frame_o   = new_frame_q;
  assign line_idx_o    = line_q;
  assign frame_idx_o   = frame_q;
  assign scan_active_o = scan_active_q;
  assign overrun_o     = overrun_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_mems_scan_sequencer.sv
// Directed testbench for mems_scan_sequencer.
// Geometry: INIT_LEN=2, SCAN_BASE=8, LINE_LEN=4, LINES=2, FRAMES=2.
// This gives scan points 8..23, line ends at 11 and 19, and frame ends at 15 and 23.
// The SPI master model stays busy for 3 cycles starting the cycle after each pulse.
module tb_mems_scan_sequencer;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          pause;
  logic          continuous;
  logic          spi_busy;
  logic          line_ack;
  logic          frame_ack;
  logic          spi_start_o;
  logic [AW-1:0] addr_o;
  logic          new_line_o;
  logic          new_frame_o;
  logic [0:0]    line_idx_o;
  logic [0:0]    frame_idx_o;
  logic          scan_active_o;
  logic          overrun_o;
  logic [1:0]    state_o;

  int checks = 0;
  int errors = 0;

  mems_scan_sequencer #(
    .ADDR_W(AW), .INIT_LEN(2), .SCAN_BASE(8),
    .LINE_LEN(4), .LINES(2), .FRAMES(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pause_i(pause),
    .continuous_i(continuous), .spi_busy_i(spi_busy),
    .line_ack_i(line_ack), .frame_ack_i(frame_ack),
    .spi_start_o(spi_start_o), .addr_o(addr_o),
    .new_line_o(new_line_o), .new_frame_o(new_frame_o),
    .line_idx_o(line_idx_o), .frame_idx_o(frame_idx_o),
    .scan_active_o(scan_active_o), .overrun_o(overrun_o),
    .state_o(state_o)
  );

  // Clock / reset block
  initial forever #5 clk = ~clk;

  // SPI master model
  int busy_cnt = 0;
  initial begin
    spi_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst)              busy_cnt = 0;
      else if (spi_start_o) busy_cnt = 3;
      else if (busy_cnt > 0) busy_cnt--;
      spi_busy = (busy_cnt > 0);
    end
  end

  // Ack model: acknowledges a flag one cycle after it is raised.
  logic auto_line  = 1'b1;
  logic auto_frame = 1'b1;
  logic force_line = 1'b0;
  initial begin
    line_ack  = 1'b0;
    frame_ack = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      line_ack  = (auto_line && new_line_o) || force_line;
      frame_ack = auto_frame && new_frame_o;
    end
  end

  // Pulse spacing monitor
  int   adj_viol = 0;
  logic prev_sp  = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    if (spi_start_o && prev_sp) adj_viol++;
    prev_sp = spi_start_o;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits for the next pulse, up to 40 cycles, and checks its address.
  task automatic wait_pulse(input logic [AW-1:0] exp_a, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!spi_start_o && n < 40);
    check({tag, " pulse"}, {31'd0, spi_start_o}, 32'd1);
    check({tag, " addr"}, {16'd0, addr_o}, {16'd0, exp_a});
  endtask

  // Expected indices and flags of a scan point, with acks returned promptly.
  task automatic point_check(input int a);
    check($sformatf("a%0d line_idx", a), {31'd0, line_idx_o}, ((a - 8) / 4) % 2);
    check($sformatf("a%0d frame_idx", a), {31'd0, frame_idx_o}, (a - 8) / 8);
    check($sformatf("a%0d new_line", a), {31'd0, new_line_o},
          {31'd0, (a == 11 || a == 19)});
    check($sformatf("a%0d new_frame", a), {31'd0, new_frame_o},
          {31'd0, (a == 15 || a == 23)});
    check($sformatf("a%0d overrun", a), {31'd0, overrun_o}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " spi_start"}, {31'd0, spi_start_o}, 0);
    check({tag, " addr"}, {16'd0, addr_o}, 0);
    check({tag, " new_line"}, {31'd0, new_line_o}, 0);
    check({tag, " new_frame"}, {31'd0, new_frame_o}, 0);
    check({tag, " line_idx"}, {31'd0, line_idx_o}, 0);
    check({tag, " frame_idx"}, {31'd0, frame_idx_o}, 0);
    check({tag, " scan_active"}, {31'd0, scan_active_o}, 0);
    check({tag, " overrun"}, {31'd0, overrun_o}, 0);
    check({tag, " state"}, {30'd0, state_o}, 0);
  endtask

  initial begin
    int quiet;
    rst        = 1'b1;
    start      = 1'b0;
    pause      = 1'b0;
    continuous = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Init sequence, continuous mode: the pulse follows start by one cycle.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("init0 pulse", {31'd0, spi_start_o}, 1);
    check("init0 addr", {16'd0, addr_o}, 0);
    check("init0 state", {30'd0, state_o}, 1);
    wait_pulse(1, "init1");
    check("init1 scan_active", {31'd0, scan_active_o}, 0);
    wait_pulse(8, "scan8");
    check("scan8 scan_active", {31'd0, scan_active_o}, 1);
    check("scan8 state", {30'd0, state_o}, 2);
    point_check(8);
    for (int a = 9; a <= 23; a++) begin
      wait_pulse(AW'(a), "pass1");
      point_check(a);
    end

    // Wrap back to the first scan point.
    wait_pulse(8, "wrap");
    point_check(8);
    for (int a = 9; a <= 12; a++) begin
      wait_pulse(AW'(a), "pass2");
      point_check(a);
    end

    // Pause for 10 cycles after the addr-12 pulse.
    pause = 1'b1;
    quiet = 0;
    repeat (10) begin
      @(negedge clk);
      if (spi_start_o) quiet++;
    end
    pause = 1'b0;
    check("pause no pulses", quiet, 0);
    wait_pulse(13, "resume");
    point_check(13);
    for (int a = 14; a <= 23; a++) begin
      wait_pulse(AW'(a), "pass2b");
      point_check(a);
    end
    wait_pulse(8, "wrap2");

    // Overrun: withhold line_ack across the line ends at 11 and 19.
    auto_line = 1'b0;
    for (int a = 9; a <= 19; a++) begin
      wait_pulse(AW'(a), "ovr");
      if (a == 11) begin
        check("ovr a11 new_line", {31'd0, new_line_o}, 1);
        check("ovr a11 overrun", {31'd0, overrun_o}, 0);
      end
      if (a == 15) check("ovr a15 new_frame", {31'd0, new_frame_o}, 1);
    end
    check("ovr a19 new_line", {31'd0, new_line_o}, 1);
    check("ovr a19 overrun", {31'd0, overrun_o}, 1);

    // Set/ack race: line_ack is held high through the edge that issues 11.
    for (int a = 20; a <= 23; a++) wait_pulse(AW'(a), "race");
    wait_pulse(8, "race");
    wait_pulse(9, "race");
    wait_pulse(10, "race");
    force_line = 1'b1;
    @(negedge clk);
    check("ack clears new_line", {31'd0, new_line_o}, 0);
    wait_pulse(11, "race");
    force_line = 1'b0;
    check("race set wins", {31'd0, new_line_o}, 1);
    check("overrun sticky", {31'd0, overrun_o}, 1);

    // Asynchronous reset mid-scan.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("async rst");
    auto_line = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    continuous = 1'b0;
    @(negedge clk);

    // Single-shot pass after reset; init is replayed.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ss init0 pulse", {31'd0, spi_start_o}, 1);
    check("ss init0 addr", {16'd0, addr_o}, 0);
    wait_pulse(1, "ss init1");
    wait_pulse(8, "ss");
    point_check(8);
    for (int a = 9; a <= 23; a++) begin
      wait_pulse(AW'(a), "ss");
      point_check(a);
    end
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      if (spi_start_o) quiet++;
    end
    check("done no pulses", quiet, 0);
    check("done state", {30'd0, state_o}, 3);
    check("done addr", {16'd0, addr_o}, 23);
    check("done scan_active", {31'd0, scan_active_o}, 0);

    // Restart from DONE: the scan starts again without replaying init.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart pulse", {31'd0, spi_start_o}, 1);
    check("restart addr", {16'd0, addr_o}, 8);
    check("restart scan_active", {31'd0, scan_active_o}, 1);
    check("restart state", {30'd0, state_o}, 2);
    wait_pulse(9, "restart next");

    check("pulse spacing", adj_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mems_scan_sequencer.md
# mems_scan_sequencer

Parametrised MEMS mirror scan sequencer: drives the DAC SPI master with a command-ROM address stream and a one-cycle start pulse per command, first replaying an initialisation command list and then sweeping a line/frame-structured scan region. Raises line and frame boundary flags for the downstream FIFO/readout logic and clears them on acknowledge. It adds a configurable geometry, single-shot or continuous mode, and an overrun indication. Sits between the top-level control and `mems_SPI`/command ROM.

## Interface
- `ADDR_W`, 16: ROM address width.
- `INIT_LEN`, 2: init commands at ROM addresses 0..INIT_LEN-1 (≥1).
- `SCAN_BASE`, 8: ROM address of the first scan point (≥INIT_LEN).
- `LINE_LEN`, 720: points per line (≥2).
- `LINES`, 2: lines per frame (≥1).
- `FRAMES`, 9: frames per scan pass (≥1). Derived: `N = LINE_LEN*LINES*FRAMES`; `SCAN_END = SCAN_BASE+N-1` (must fit in ADDR_W).
- `clk` in 1: system clock.
- `rst` in 1: reset. Asynchronous, active-high.
- `start` in 1: begin the sequence; level-sampled.
- `pause` in 1: holds scan issuing.
- `continuous` in 1: 1 = wrap forever; 0 = one pass, then stop.
- `spi_busy` in 1: SPI master busy.
- `line_ack` in 1: clears `new_line`.
- `frame_ack` in 1: clears `new_frame`.
- `spi_start` out 1: one-cycle command start pulse.
- `addr` out ADDR_W: ROM address of the command being started.
- `new_line` out 1: line-boundary flag.
- `new_frame` out 1: frame-boundary flag.
- `line_idx` out clog2(LINES) (min 1): line index within the current frame.
- `frame_idx` out clog2(FRAMES) (min 1): frame index within the pass.
- `scan_active` out 1: high in SCAN.
- `overrun` out 1: sticky flag, set when a boundary flag is lost.

## Operation
- States: IDLE, INIT, SCAN, DONE. Reset value of every output and register is 0, and the state is IDLE.
- Issue condition `go`: `spi_busy==0` and `spi_start` was low in the previous cycle. Every pulse is therefore followed by at least one gap cycle.
- IDLE: on `start`, issue addr 0, clear `overrun`, and go to INIT.
- INIT: on `go`, issue the next init address. After issuing INIT_LEN-1, the next `go` issues SCAN_BASE and the state goes to SCAN. `pause` is ignored in INIT.
- SCAN: on `go && !pause`, issue `addr+1`. `line_idx`/`frame_idx` track the point just issued.
- Line boundary: a pulse whose addr is the last point of a line (`(addr-SCAN_BASE+1) % LINE_LEN == 0`) that is not the last line of a frame sets `new_line`.
- Frame boundary: the last point of a frame sets `new_frame` only, not `new_line`. Frame has priority.
- After SCAN_END is issued:
  - continuous=1: the next `go` issues SCAN_BASE, and both indices return to 0.
  - continuous=0: state goes to DONE and `scan_active` falls. `addr` holds SCAN_END.
- DONE: on `start`, issue SCAN_BASE and go to SCAN. Init is not replayed.
- Flag clearing: `line_ack`/`frame_ack` clear their flag the next cycle. If a set and an ack for the same flag occur in the same cycle, set wins.
- `overrun` sets when a set event hits a flag that is already high with no ack in that cycle. It is cleared only by `rst` or by `start` from IDLE.
- `start` is ignored in INIT and SCAN.

## Timing
- All outputs are registered. `addr` changes in the same cycle `spi_start` is high and is stable until the next pulse.
- `new_line`/`new_frame` rise in the same cycle as the boundary pulse.
- Latency: `start` high at edge k gives `spi_start` at cycle k+1.
- With `spi_busy` tied low, pulses occur every 2 cycles.
- `pause` sampled high at an edge where `go` holds suppresses that pulse. Deasserting `pause` resumes on the next `go`, with no address skipped or repeated.
- Asynchronous reset mid-operation: outputs drop to 0 immediately. An in-flight SPI transfer is not tracked, and the next `start` replays init.

## Test plan
Bench parameters: INIT_LEN=2, SCAN_BASE=8, LINE_LEN=4, LINES=2, FRAMES=2, so N=16 and SCAN_END=23. SPI model: busy for 3 cycles starting the cycle after the pulse.
- Init sequence: `start` pulse, continuous=1 -> pulses with addr 0, 1, 8, 9, 10…, `scan_active` rises with addr 8, and no pulse is closer than 2 cycles.
- Boundaries: acks are returned 1 cycle after each flag -> `new_line` at addr 11 and 19; `new_frame` at addr 15 and 23; `frame_idx` becomes 1 at addr 16; `overrun` stays 0.
- Wrap: continuous=1 -> the pulse after addr 23 carries addr 8, with `line_idx`=0 and `frame_idx`=0.
- Single-shot: continuous=0 -> after addr 23, no further pulses, state DONE, `addr`=23, `scan_active`=0. A `start` then gives next pulse addr 8, with no init replay.
- Pause: `pause` high for 10 cycles after the addr-12 pulse -> no pulses during pause; the next pulse is addr 13.
- Overrun, set/ack race and reset:
  - Withhold `line_ack` across addr 11 and 19 -> `overrun`=1 at the addr-19 pulse.
  - `line_ack` in the same cycle as a set -> `new_line` stays 1.
  - `rst` mid-scan -> all outputs 0 asynchronously; a subsequent `start` gives addr 0.
